// File: rtl/cordic_mult_seq_ctrl.sv
// cordic_mult_seq_ctrl
//
// Upstream sequencer and result collector for the 8-bit approximate CORDIC
// multiplier. An (x, z) pair taken from the input stream is latched onto the
// multiplier inputs. start is held high until done arrives, then y is
// captured. start is dropped for one FLUSH cycle so the multiplier clears its
// iteration counter. The result is then offered on the output stream. If done
// never arrives, the transaction is aborted with out_err set.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   in_valid/in_ready     operand stream handshake (in_ready only in IDLE)
//   in_x, in_z            signed multiplicand, signed Q1.7 multiplier
//   out_valid/out_ready   result stream handshake
//   out_y, out_err        captured y (0 on timeout), timeout flag
//   busy                  high in every state except IDLE
//   mul_start             level-sensitive start to the multiplier
//   mul_x, mul_z          registered operands to the multiplier
//   mul_y, mul_done       multiplier result and done
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// RUN   | multiplier running with start=1, watching done and the timeout
// FLUSH | start=0 for one cycle so the multiplier clears its counter
// OUT   | result presented, waiting for out_ready

module cordic_mult_seq_ctrl #(
  parameter int MAX_ITERATIONS = 16,
  parameter int TIMEOUT_CYCLES = 24,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_x,
  input  logic [7:0]  in_z,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_y,
  output logic        out_err,
  output logic        busy,
  output logic        mul_start,
  output logic [7:0]  mul_x,
  output logic [7:0]  mul_z,
  input  logic [15:0] mul_y,
  input  logic        mul_done
);

  // The timeout must leave room for a normally completing multiply, and the
  // counter must be able to reach its saturation value.
  if (TIMEOUT_CYCLES <= MAX_ITERATIONS) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must exceed MAX_ITERATIONS");
  end
  if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] run_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      busy      <= 1'b0;
      mul_start <= 1'b0;
      out_y     <= '0;
      mul_x     <= '0;
      mul_z     <= '0;
      run_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mul_x     <= in_x;
            mul_z     <= in_z;
            run_cnt   <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            mul_start <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (run_cnt != CNT_SAT) begin
            run_cnt <= run_cnt + CNT_W'(1);
          end
          // done wins over a timeout landing on the same edge
          if (mul_done) begin
            out_y     <= mul_y;
            out_err   <= 1'b0;
            mul_start <= 1'b0;
            state     <= FLUSH;
          end else if (run_cnt == CNT_LAST) begin
            out_y     <= '0;
            out_err   <= 1'b1;
            mul_start <= 1'b0;
            state     <= FLUSH;
          end
        end
        FLUSH: begin
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_mult_seq_ctrl.sv
// Bench for cordic_mult_seq_ctrl. A behavioural multiplier stands in for the
// CORDIC core. It counts cycles while start is high, raises done after 16 of
// them, and can be made to hang. Expected results come from plain x*z
// arithmetic and from cycle counts derived from the sequencing rules.

module tb_cordic_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_x = '0;
  logic [7:0]  in_z = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_y;
  logic        out_err;
  logic        busy;
  logic        mul_start;
  logic [7:0]  mul_x;
  logic [7:0]  mul_z;
  logic [15:0] mul_y;
  logic        mul_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural multiplier: exact product, done after 16 start-high edges
  logic [4:0]  stub_cnt = '0;
  logic        stub_hang = 1'b0;
  logic [15:0] sx, sz;
  always @(posedge clk) begin
    if (!mul_start) stub_cnt <= '0;
    else if (stub_cnt < 5'd16) stub_cnt <= stub_cnt + 5'd1;
  end
  assign sx = {{8{mul_x[7]}}, mul_x};
  assign sz = {{8{mul_z[7]}}, mul_z};
  assign mul_y = sx * sz;
  assign mul_done = !stub_hang && (stub_cnt == 5'd16);

  cordic_mult_seq_ctrl #(.MAX_ITERATIONS(16), .TIMEOUT_CYCLES(24), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_err(out_err),
    .busy(busy), .mul_start(mul_start), .mul_x(mul_x), .mul_z(mul_z),
    .mul_y(mul_y), .mul_done(mul_done)
  );

  function automatic logic [15:0] ref_y(input int x, input int z);
    return 16'(x * z);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // call at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic accept(input int x, input int z, output bit ok);
    ok = 1'b0;
    in_x = 8'(x);
    in_z = 8'(z);
    in_valid = 1'b1;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        ok = 1'b1;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  // lat = edges after acceptance at which out_valid is first seen
  task automatic wait_out(output int lat, output logic [15:0] y, output logic err,
                          output int start_hi, output bit ok);
    ok = 1'b0;
    lat = -1;
    y = '0;
    err = 1'b0;
    start_hi = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (mul_start) start_hi++;
      if (out_valid) begin
        lat = n;
        y = out_y;
        err = out_err;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL reset_mul_start: got %b expected 0", mul_start); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b expected 0", out_err); end
    checks++; if ({out_y, mul_x, mul_z} !== 32'd0) begin errors++; $display("FAIL reset_regs: got y=%0h x=%0h z=%0h expected 0", out_y, mul_x, mul_z); end
    tick();
  endtask

  task automatic test_nominal();
    bit ok, ok2; int lat, sh; logic [15:0] y; logic err;
    out_ready = 1'b1;
    accept(64, 64, ok);
    checks++; if (!ok) begin errors++; $display("FAIL nominal_accept: got no handshake expected handshake"); end
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL nominal_busy: got busy=%b in_ready=%b expected 1/0", busy, in_ready); end
    wait_out(lat, y, err, sh, ok2);
    checks++; if (!ok2 || lat != 18) begin errors++; $display("FAIL nominal_latency: got %0d expected 18", lat); end
    checks++; if (y !== 16'd4096) begin errors++; $display("FAIL nominal_y: got %0d expected 4096", $signed(y)); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL nominal_err: got %b expected 0", err); end
    checks++; if (sh != 17) begin errors++; $display("FAIL nominal_start_cycles: got %0d expected 17", sh); end
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL nominal_return_idle: got ov=%b ir=%b busy=%b expected 0/1/0", out_valid, in_ready, busy); end
    tick();
  endtask

  task automatic test_signed();
    int xs[8], zs[8];
    xs[0] = -100; zs[0] = -32;
    xs[1] = 127;  zs[1] = 127;
    for (int i = 2; i < 8; i++) begin
      xs[i] = int'($urandom_range(0, 255)) - 128;
      zs[i] = int'($urandom_range(0, 255)) - 128;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bit ok, ok2; int lat, sh; logic [15:0] y; logic err;
      accept(xs[i], zs[i], ok);
      wait_out(lat, y, err, sh, ok2);
      checks++; if (!ok || !ok2 || lat != 18) begin errors++; $display("FAIL signed_latency[%0d]: got %0d expected 18", i, lat); end
      checks++; if (y !== ref_y(xs[i], zs[i])) begin errors++; $display("FAIL signed_y[%0d] x=%0d z=%0d: got %0d expected %0d", i, xs[i], zs[i], $signed(y), xs[i] * zs[i]); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL signed_err[%0d]: got %b expected 0", i, err); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit ok, ok2; int lat, sh; logic [15:0] y, held; logic err;
    out_ready = 1'b0;
    accept(-7, 90, ok);
    wait_out(lat, held, err, sh, ok2);
    checks++; if (!ok || !ok2 || held !== ref_y(-7, 90)) begin errors++; $display("FAIL bp_first_y: got %0d expected %0d", $signed(held), -630); end
    for (int i = 0; i < 10; i++) begin
      tick();
      in_valid = (i % 2 == 0);
      in_x = 8'(i * 13 + 1);
      in_z = 8'(i * 7 + 3);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_y !== held || out_err !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d]: got ov=%b y=%0h err=%b expected 1/%0h/0", i, out_valid, out_y, out_err, held); end
      checks++; if (in_ready !== 1'b0 || mul_x !== 8'(-7) || mul_z !== 8'(90)) begin errors++; $display("FAIL bp_no_accept[%0d]: got ir=%b x=%0h z=%0h expected 0/f9/5a", i, in_ready, mul_x, mul_z); end
    end
    tick();
    in_valid = 1'b1;
    in_x = 8'(55);
    in_z = 8'(-3);
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got ir=%b ov=%b expected 1/0", in_ready, out_valid); end
    tick();
    in_valid = 1'b0;
    wait_out(lat, y, err, sh, ok2);
    checks++; if (!ok2 || lat != 18) begin errors++; $display("FAIL bp_next_latency: got %0d expected 18", lat); end
    checks++; if (y !== ref_y(55, -3) || err !== 1'b0 || mul_x !== 8'(55)) begin errors++; $display("FAIL bp_next_y: got %0d err=%b expected -165/0", $signed(y), err); end
    tick();
  endtask

  task automatic test_timeout();
    bit ok, ok2; int lat, sh; logic [15:0] y; logic err;
    out_ready = 1'b1;
    stub_hang = 1'b1;
    accept(20, 30, ok);
    wait_out(lat, y, err, sh, ok2);
    // timeout edge is the 24th RUN edge, then one FLUSH edge
    checks++; if (!ok || !ok2 || lat != 25) begin errors++; $display("FAIL timeout_latency: got %0d expected 25", lat); end
    checks++; if (err !== 1'b1 || y !== 16'd0) begin errors++; $display("FAIL timeout_result: got err=%b y=%0d expected 1/0", err, y); end
    checks++; if (sh != 24) begin errors++; $display("FAIL timeout_start_cycles: got %0d expected 24", sh); end
    tick();
    stub_hang = 1'b0;
    accept(-50, 77, ok);
    wait_out(lat, y, err, sh, ok2);
    checks++; if (!ok2 || lat != 18 || y !== ref_y(-50, 77) || err !== 1'b0) begin errors++; $display("FAIL timeout_recover: got lat=%0d y=%0d err=%b expected 18/-3850/0", lat, $signed(y), err); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    bit ok, ok2; int lat, sh; logic [15:0] y; logic err;
    out_ready = 1'b1;
    accept(33, -44, ok);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (mul_start !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midrun_reset: got st=%b busy=%b ov=%b ir=%b expected 0/0/0/1", mul_start, busy, out_valid, in_ready); end
    checks++; if (mul_x !== 8'd0 || mul_z !== 8'd0) begin errors++; $display("FAIL midrun_operands: got x=%0h z=%0h expected 0/0", mul_x, mul_z); end
    tick();
    accept(-128, 127, ok);
    wait_out(lat, y, err, sh, ok2);
    checks++; if (!ok || !ok2 || lat != 18) begin errors++; $display("FAIL midrun_next_latency: got %0d expected 18", lat); end
    checks++; if (y !== ref_y(-128, 127) || err !== 1'b0) begin errors++; $display("FAIL midrun_next_y: got %0d err=%b expected -16256/0", $signed(y), err); end
    tick();
  endtask

  task automatic test_back_to_back();
    int xs[4], zs[4], acc[4];
    int hs_q[$];
    logic [15:0] y_q[$];
    logic e_q[$];
    int idx, extra;
    bit took;
    for (int i = 0; i < 4; i++) begin
      xs[i] = int'($urandom_range(0, 255)) - 128;
      zs[i] = int'($urandom_range(0, 255)) - 128;
      acc[i] = 0;
    end
    out_ready = 1'b1;
    idx = 0;
    in_x = 8'(xs[0]);
    in_z = 8'(zs[0]);
    in_valid = 1'b1;
    for (int n = 0; n < 200 && y_q.size() < 4; n++) begin
      @(negedge clk);
      took = 1'b0;
      if (in_valid && in_ready) begin
        if (idx < 4) acc[idx] = cyc + 1;
        took = 1'b1;
      end
      if (out_valid && out_ready) begin
        hs_q.push_back(cyc + 1);
        y_q.push_back(out_y);
        e_q.push_back(out_err);
      end
      tick();
      if (took) begin
        idx++;
        if (idx < 4) begin
          in_x = 8'(xs[idx]);
          in_z = 8'(zs[idx]);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    extra = 0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    checks++; if (y_q.size() != 4 || idx != 4) begin errors++; $display("FAIL b2b_count: got results=%0d accepts=%0d expected 4/4", y_q.size(), idx); end
    checks++; if (extra != 0) begin errors++; $display("FAIL b2b_extra_results: got %0d expected 0", extra); end
    for (int i = 0; i < y_q.size() && i < 4; i++) begin
      checks++; if (y_q[i] !== ref_y(xs[i], zs[i]) || e_q[i] !== 1'b0) begin errors++; $display("FAIL b2b_y[%0d]: got %0d err=%b expected %0d/0", i, $signed(y_q[i]), e_q[i], xs[i] * zs[i]); end
      checks++; if (hs_q[i] - acc[i] != 19) begin errors++; $display("FAIL b2b_handshake_gap[%0d]: got %0d expected 19", i, hs_q[i] - acc[i]); end
      if (i > 0) begin
        checks++; if (acc[i] - acc[i-1] != 20) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected 20", i, acc[i] - acc[i-1]); end
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_signed();
    test_backpressure();
    test_timeout();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
